bram_disp_map: RTL and testbench

- Read-only disparity-map engine on port B of a dual-port 32-bit block RAM holding a ROWS×WIDTH strip of a stereo pair.
- On `go`, computes a block-matching (SAD) disparity for every column of the strip's centre row.
- Pushes one result word per column into a downstream FIFO, respecting `busy` back-pressure.
- Signals completion with `done`.

---
 rtl/bram_disp_map.sv | 217 +++++++++++++++++++++
 tb/tb_bram_disp_map.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_disp_map.sv
// Purpose: SAD block-matching disparity over the centre row of a ROWS x WIDTH stereo strip held in
//          block RAM port B.
// Latency: per column MAX_DISP*(4*(2h+1)^2 + 2) + 1 cycles (four-cycle sequential L/R read per term).
// Backpressure: the result word is held in EMIT while busy=1; wr_en_fifo fires only in a busy=0 cycle.
// Ports: clkb/reset (async active-low) | go (level start), window (h = window>>1), busy (FIFO full)
//        doutb (RAM data, 1-cycle read latency) -> enb/web/addrb (RAM port B, read-only)
//        done (frame complete, held until go=0), wr_en_fifo/din_fifo ({x, 8'd0, best_d}).
module bram_disp_map #(
  parameter int WIDTH    = 640,
  parameter int ROWS     = 7,
  parameter int MAX_DISP = 16
) (
  input  logic        clkb,
  input  logic        reset,
  input  logic        go,
  input  logic [2:0]  window,
  input  logic        busy,
  input  logic [31:0] doutb,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] addrb,
  output logic        done,
  output logic        wr_en_fifo,
  output logic [31:0] din_fifo
);

  localparam int                 C         = ROWS / 2;
  localparam logic signed [17:0] COL_MAX_S = 18'(WIDTH - 1);
  localparam logic        [15:0] COL_MAX_U = 16'(WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_DISP, S_RD_L, S_RD_R, S_GET_L, S_GET_R, S_CMP, S_EMIT, S_DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         h_q;
  logic [15:0]        x_q;
  logic [7:0]         d_q;
  logic [15:0]        r_q;
  logic signed [3:0]  k_q;
  logic [13:0]        sad_q;
  logic [13:0]        bsad_q;
  logic [7:0]         bdisp_q;
  logic [7:0]         l_q;
  logic               enb_q;
  logic [31:0]        addrb_q;
  logic               done_q;
  logic [31:0]        din_q;

  // Combinational helpers
  logic signed [3:0]  h_s;
  logic signed [17:0] col_l_raw;
  logic signed [17:0] col_r_raw;
  logic [15:0]        col_l;
  logic [15:0]        col_r;
  logic [31:0]        row_base;
  logic [31:0]        addr_l_d;
  logic [31:0]        addr_r_d;
  logic [7:0]         pix_r;
  logic [7:0]         adiff;
  logic [13:0]        sad_d;
  logic               take_best;
  logic [13:0]        bsad_d;
  logic [7:0]         bdisp_d;
  logic               last_k;
  logic               last_r;
  logic               last_d;
  logic               last_x;
  logic               unused_bits;

  function automatic logic [15:0] clamp_col(input logic signed [17:0] c);
    if (c < 18'sd0) begin
      clamp_col = 16'd0;
    end else if (c > COL_MAX_S) begin
      clamp_col = COL_MAX_U;
    end else begin
      clamp_col = c[15:0];
    end
  endfunction

  assign h_s       = $signed({2'b00, h_q});
  assign col_l_raw = $signed({2'b00, x_q}) + $signed({{14{k_q[3]}}, k_q});
  assign col_r_raw = col_l_raw - $signed({10'b0, d_q});
  assign col_l     = clamp_col(col_l_raw);
  assign col_r     = clamp_col(col_r_raw);
  assign row_base  = 32'(r_q) * 32'(WIDTH);
  assign addr_l_d  = row_base + {16'b0, col_l};
  assign addr_r_d  = row_base + {16'b0, col_r};

  // L was captured into l_q a cycle earlier; R is on doutb now.
  assign pix_r = doutb[15:8];
  assign adiff = (l_q >= pix_r) ? (l_q - pix_r) : (pix_r - l_q);
  assign sad_d = sad_q + {6'b0, adiff};

  // Strict less-than keeps the lowest d on ties; d=0 always seeds the best.
  assign take_best = (d_q == 8'd0) || (sad_q < bsad_q);
  assign bsad_d    = take_best ? sad_q : bsad_q;
  assign bdisp_d   = take_best ? d_q   : bdisp_q;

  assign last_k = (k_q == h_s);
  assign last_r = (r_q == 16'(C) + {14'b0, h_q});
  assign last_d = (d_q == 8'(MAX_DISP - 1));
  assign last_x = (x_q == COL_MAX_U);

  // The upper data bits and window[0] carry no information for this engine.
  assign unused_bits = ^{window[0], doutb[31:16]};

  always_ff @(posedge clkb or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      h_q     <= 2'd0;
      x_q     <= 16'd0;
      d_q     <= 8'd0;
      r_q     <= 16'd0;
      k_q     <= 4'sd0;
      sad_q   <= 14'd0;
      bsad_q  <= 14'd0;
      bdisp_q <= 8'd0;
      l_q     <= 8'd0;
      enb_q   <= 1'b0;
      addrb_q <= 32'd0;
      done_q  <= 1'b0;
      din_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          enb_q  <= 1'b0;
          done_q <= 1'b0;
          if (go) begin
            h_q     <= window[2:1];
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          x_q     <= 16'd0;
          d_q     <= 8'd0;
          state_q <= S_DISP;
        end
        S_DISP: begin
          sad_q   <= 14'd0;
          r_q     <= 16'(C) - {14'b0, h_q};
          k_q     <= -h_s;
          state_q <= S_RD_L;
        end
        S_RD_L: begin
          enb_q   <= 1'b1;
          addrb_q <= addr_l_d;
          state_q <= S_RD_R;
        end
        S_RD_R: begin
          addrb_q <= addr_r_d;
          state_q <= S_GET_L;
        end
        S_GET_L: begin
          enb_q   <= 1'b0;
          l_q     <= doutb[7:0];
          state_q <= S_GET_R;
        end
        S_GET_R: begin
          sad_q <= sad_d;
          if (last_k) begin
            k_q <= -h_s;
            if (last_r) begin
              state_q <= S_CMP;
            end else begin
              r_q     <= r_q + 16'd1;
              state_q <= S_RD_L;
            end
          end else begin
            k_q     <= k_q + 4'sd1;
            state_q <= S_RD_L;
          end
        end
        S_CMP: begin
          bsad_q  <= bsad_d;
          bdisp_q <= bdisp_d;
          if (last_d) begin
            din_q   <= {x_q, 8'd0, bdisp_d};
            state_q <= S_EMIT;
          end else begin
            d_q     <= d_q + 8'd1;
            state_q <= S_DISP;
          end
        end
        S_EMIT: begin
          if (!busy) begin
            if (last_x) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              x_q     <= x_q + 16'd1;
              d_q     <= 8'd0;
              state_q <= S_DISP;
            end
          end
        end
        S_DONE: begin
          // go held high never restarts; only go=0 rearms the engine.
          if (!go) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign enb      = enb_q;
  assign web      = 4'b0000;
  assign addrb    = addrb_q;
  assign done     = done_q;
  assign din_fifo = din_q;
  // Gated by the live busy so the strobe can never coincide with a full FIFO.
  assign wr_en_fifo = (state_q == S_EMIT) && !busy;

endmodule

// File: tb/tb_bram_disp_map.sv
// Purpose: scoreboarded bench for bram_disp_map on a reduced 7x16 strip with 6 disparities.
// Latency: expected words queued at frame start; a negedge monitor pops one per FIFO write.
// Backpressure: busy is driven idle, randomly, or forced high around a chosen emit.
module tb_bram_disp_map;
  localparam int W  = 16;
  localparam int RW = 7;
  localparam int MD = 6;
  localparam int C  = RW / 2;
  localparam logic [31:0] NWORDS = 32'(RW * W);

  logic        clkb = 1'b0;
  logic        reset;
  logic        go;
  logic [2:0]  window;
  logic        busy;
  logic [31:0] doutb;
  logic        enb;
  logic [3:0]  web;
  logic [31:0] addrb;
  logic        done;
  logic        wr_en_fifo;
  logic [31:0] din_fifo;

  logic [31:0] mem [RW*W];
  logic [31:0] exp_q [$];
  logic [31:0] lf [W];
  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  int          busy_mode = 0;
  logic [31:0] max_addr = 32'd0;
  bit          web_bad = 1'b0;
  logic [31:0] held;

  bram_disp_map #(.WIDTH(W), .ROWS(RW), .MAX_DISP(MD)) dut (
    .clkb(clkb), .reset(reset), .go(go), .window(window), .busy(busy), .doutb(doutb),
    .enb(enb), .web(web), .addrb(addrb), .done(done), .wr_en_fifo(wr_en_fifo), .din_fifo(din_fifo)
  );

  always #5 clkb = ~clkb;

  // Block RAM port B: one-cycle registered read.
  always @(posedge clkb) begin
    if (enb) doutb <= (addrb < NWORDS) ? mem[addrb] : 32'hFFFF_FFFF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clampc(input int c);
    if (c < 0) return 0;
    if (c > W - 1) return W - 1;
    return c;
  endfunction

  // Reference: brute-force SAD over the whole search range for every column.
  task automatic push_frame(input int win);
    int h, best, bsad, sad;
    logic [31:0] wl, wr;
    h = win >> 1;
    for (int x = 0; x < W; x++) begin
      best = 0;
      bsad = 0;
      for (int d = 0; d < MD; d++) begin
        sad = 0;
        for (int r = C - h; r <= C + h; r++) begin
          for (int k = -h; k <= h; k++) begin
            wl = mem[r * W + clampc(x + k)];
            wr = mem[r * W + clampc(x + k - d)];
            sad += absd(int'(wl[7:0]), int'(wr[15:8]));
          end
        end
        if (d == 0 || sad < bsad) begin
          best = d;
          bsad = sad;
        end
      end
      exp_q.push_back({x[15:0], 8'd0, best[7:0]});
    end
  endtask

  // Monitor: every FIFO write is popped against the scoreboard.
  always @(negedge clkb) begin
    if (enb && addrb > max_addr) max_addr = addrb;
    if (web != 4'd0) web_bad = 1'b1;
    if (wr_en_fifo) begin
      check("wr_while_busy", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h expected=none", din_fifo);
      end else begin
        check("fifo_word", din_fifo, exp_q.pop_front());
      end
      if (din_fifo[31:16] < 16'(W)) lf[din_fifo[31:16]] = din_fifo;
      wr_count++;
    end
  end

  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clkb);
      #1;
      case (busy_mode)
        1:       busy = ($urandom_range(0, 2) == 0);
        2:       busy = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

  task automatic start_frame(input int win);
    @(posedge clkb);
    #1;
    window   = 3'(win);
    max_addr = 32'd0;
    web_bad  = 1'b0;
    wr_count = 0;
    for (int i = 0; i < W; i++) lf[i] = 32'hFFFF_FFFF;
    push_frame(win);
    go = 1'b1;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int budget;
    budget = 40000;
    while (wr_count < n && budget > 0) begin
      @(negedge clkb);
      budget--;
    end
    if (wr_count < n) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout writes=%0d expected=%0d", tag, wr_count, n);
    end
  endtask

  task automatic finish_frame(input bit keep_go);
    int budget;
    budget = 60000;
    while (!done && budget > 0) begin
      @(negedge clkb);
      budget--;
    end
    check("done_set", {31'd0, done}, 32'd1);
    check("write_count", wr_count, W);
    check("queue_empty", exp_q.size(), 0);
    check("addr_out_of_range", {31'd0, max_addr > NWORDS - 1}, 32'd0);
    check("web_nonzero", {31'd0, web_bad}, 32'd0);
    exp_q.delete();
    if (!keep_go) begin
      @(posedge clkb);
      #1;
      go = 1'b0;
      repeat (3) @(negedge clkb);
      check("done_cleared", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int budget;
    go     = 1'b0;
    window = 3'd0;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
    repeat (3) @(posedge clkb);
    #1;
    check("rst_enb", {31'd0, enb}, 32'd0);
    check("rst_web", {28'd0, web}, 32'd0);
    check("rst_addrb", addrb, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en_fifo}, 32'd0);
    check("rst_din", din_fifo, 32'd0);
    reset = 1'b1;

    // Uniform image: every SAD ties, so d=0 everywhere.
    for (int i = 0; i < RW * W; i++) mem[i] = 32'h0000_0001;
    start_frame(3);
    finish_frame(1'b0);
    check("uniform_x0", lf[0], 32'h0000_0000);
    check("uniform_xlast", lf[W-1], {16'(W - 1), 16'd0});

    // Single bright feature shifted by 5 between left and right.
    for (int i = 0; i < RW * W; i++) mem[i] = 32'd0;
    mem[C * W + 12] = 32'h0000_00C8;
    mem[C * W + 7]  = 32'h0000_C800;
    start_frame(1);
    finish_frame(1'b0);
    check("spike_w1_x12", lf[12], {16'd12, 8'd0, 8'd5});
    check("spike_w1_x0", lf[0], 32'h0000_0000);
    check("spike_w1_x15", lf[15], {16'd15, 16'd0});
    start_frame(7);
    finish_frame(1'b0);
    check("spike_w7_x12", lf[12], {16'd12, 8'd0, 8'd5});
    check("spike_w7_x2", lf[2], {16'd2, 16'd0});

    // Busy held across the tenth emit.
    for (int i = 0; i < RW * W; i++) mem[i] = $urandom;
    start_frame(3);
    wait_writes(9, "pre_busy");
    @(posedge clkb);
    #1;
    busy_mode = 2;
    budget = 5000;
    while (din_fifo[31:16] != 16'd9 && budget > 0) begin
      @(negedge clkb);
      budget--;
    end
    check("x9_presented", {16'd0, din_fifo[31:16]}, 32'd9);
    held = din_fifo;
    repeat (20) @(negedge clkb);
    check("no_write_while_busy", wr_count, 9);
    check("din_held", din_fifo, held);
    @(posedge clkb);
    #1;
    busy_mode = 0;
    wait_writes(10, "post_busy");
    check("x9_written", lf[9], held);
    busy_mode = 1;
    finish_frame(1'b0);
    busy_mode = 0;

    // Reset mid-frame with go still high restarts from x=0.
    for (int i = 0; i < RW * W; i++) mem[i] = $urandom;
    start_frame(2);
    wait_writes(5, "pre_reset");
    @(posedge clkb);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_enb", {31'd0, enb}, 32'd0);
    check("mid_rst_addrb", addrb, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_wr_en", {31'd0, wr_en_fifo}, 32'd0);
    check("mid_rst_din", din_fifo, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clkb);
    check("no_write_in_reset", wr_count, 5);
    push_frame(2);
    wr_count = 0;
    max_addr = 32'd0;
    @(posedge clkb);
    #1;
    reset = 1'b1;
    finish_frame(1'b0);

    // Small pixel range forces ties; random busy; window changed mid-frame.
    for (int i = 0; i < RW * W; i++) mem[i] = $urandom & 32'hFFFF_0303;
    start_frame(5);
    busy_mode = 1;
    repeat (200) @(posedge clkb);
    #1;
    window = 3'd1;
    finish_frame(1'b0);
    busy_mode = 0;

    // go held high after done: no rerun; go low clears done; second frame identical.
    for (int i = 0; i < RW * W; i++) mem[i] = $urandom;
    start_frame(0);
    finish_frame(1'b1);
    repeat (60) @(negedge clkb);
    check("no_rerun_writes", wr_count, W);
    check("done_held", {31'd0, done}, 32'd1);
    @(posedge clkb);
    #1;
    go = 1'b0;
    repeat (3) @(negedge clkb);
    check("done_cleared_go0", {31'd0, done}, 32'd0);
    start_frame(0);
    finish_frame(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
